bus_arb: RTL and testbench
==========================

BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 Parameter: TMO_BITS, default 8, width of the slave timeout counter (used only when BUS_ARB_TMO_EN is defined).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 m0_stb, m1_stb  in  1  master request/strobe (m0: CPU bus interface, m1: DMA/second master).
REQ-006 m0_we, m1_we  in  1  master write enable.
REQ-007 m0_addr, m1_addr  in  30  word address [31:2].
REQ-008 m0_dout, m1_dout  in  32  master write data.
REQ-009 m0_din, m1_din  out  32  read data, both driven from bus_din.
REQ-010 m0_ack, m1_ack  out  1  transfer acknowledge to the master.
REQ-011 bus_stb, bus_we  out  1  shared bus strobe and write enable.
REQ-012 bus_addr  out  30  shared bus word address [31:2].
REQ-013 bus_dout  out  32  shared bus write data.
REQ-014 bus_din  in  32  shared bus read data.
REQ-015 bus_ack  in  1  slave acknowledge.
REQ-016 gnt  out  2  one-hot registered grant: bit0 = m0, bit1 = m1, 00 = idle.
REQ-017 err  out  1  sticky timeout flag.
REQ-018 err_clr  in  1  synchronous clear of err.

Function
REQ-019 State machine: IDLE, GNT0, GNT1; state held in registers; gnt = {state==GNT1, state==GNT0}.
REQ-020 Grant latency is one cycle: a request seen in IDLE drives bus_stb on the following cycle.
REQ-021 IDLE with only one mx_stb high -> GNTx.
REQ-022 IDLE with both high -> grant the master not in the 1-bit register last; last updates on every grant.
REQ-023 GNTx is held while mx_stb stays high, across any number of bus_ack pulses, so multi-access sequences (e.g. byte/halfword read-modify-write) are never split.
REQ-024 GNTx with mx_stb low -> GNTy if my_stb high, else IDLE; no idle cycle is inserted on a direct hand-over.
REQ-025 In GNTx: bus_stb = mx_stb; bus_we, bus_addr, bus_dout = master x signals (combinational mux); mx_ack = bus_ack; my_ack = 0.
REQ-026 In IDLE: bus_stb = 0, bus_we = 0, bus_addr = 0, bus_dout = 0, m0_ack = m1_ack = 0.
REQ-027 m0_din and m1_din equal bus_din in all states; masters qualify them with their own ack.
REQ-028 A non-granted master's ack stays 0 regardless of bus_ack.

Reset
REQ-029 While rst_n is low: state = IDLE, last = 1 (m0 wins the first tie), err = 0, and the timeout counter = 0.
REQ-030 Reset asserted mid-transfer drops gnt and bus_stb immediately (asynchronously); no ack is issued for the aborted transfer.
REQ-031 After rst_n deasserts, the first arbitration occurs on the next rising edge.

Configuration
REQ-032 Macro BUS_ARB_TMO_EN defined: a TMO_BITS counter increments each cycle bus_stb = 1 and bus_ack = 0, and clears on bus_ack, on bus_stb = 0, or on a grant change.
REQ-033 With BUS_ARB_TMO_EN, when the counter reaches all-ones with no bus_ack, the granted mx_ack pulses 1 for one cycle, the counter clears, and err sets.
REQ-034 With BUS_ARB_TMO_EN, err_clr = 1 clears err; a simultaneous set wins over the clear.
REQ-035 BUS_ARB_TMO_EN undefined: no counter is built, err is tied 0, err_clr is ignored, and a missing ack stalls the bus indefinitely.

Verification
REQ-036 m0_stb=1 read at addr 30'h100, bus_ack after 3 cycles, bus_din=32'hDEADBEEF -> gnt=01 one cycle after request, m0_ack pulses with m0_din=32'hDEADBEEF, and m1_ack stays 0.
REQ-037 m0 and m1 raise stb in the same cycle after reset -> m0 is granted first; after m0_stb drops, gnt=10 on the next edge with no IDLE cycle.
REQ-038 m0 holds stb across two acks (read then write of a byte write) while m1 requests -> gnt stays 01 until m0_stb drops, and the bus shows addr and dout of m0 only.
REQ-039 rst_n pulled low during a GNT1 write -> bus_stb=0 and gnt=00 within the same cycle, no m1_ack, and the next tie is won by m0.
REQ-040 BUS_ARB_TMO_EN defined, TMO_BITS=8, bus_ack never asserted -> m0_ack pulses once 255 cycles after bus_stb rises, err=1; err_clr=1 returns err to 0.
REQ-041 BUS_ARB_TMO_EN undefined, same stimulus -> no ack after 1000 cycles and err=0.

Source files
------------

// File: rtl/bus_arb.sv
// Two-master bus arbiter: one-cycle grant latency, grant held while the owner strobes, round-robin on ties.
// Optional slave timeout (fake ack + sticky err) is built only when BUS_ARB_TMO_EN is defined.
//
// state | meaning
// IDLE  | no master owns the bus, bus outputs parked at zero
// GNT0  | m0 (CPU) owns the bus
// GNT1  | m1 (DMA) owns the bus
module bus_arb #(
  parameter int TMO_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [29:0] m0_addr,
  input  logic [31:0] m0_dout,
  output logic [31:0] m0_din,
  output logic        m0_ack,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [29:0] m1_addr,
  input  logic [31:0] m1_dout,
  output logic [31:0] m1_din,
  output logic        m1_ack,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_dout,
  input  logic [31:0] bus_din,
  input  logic        bus_ack,
  output logic [1:0]  gnt,
  output logic        err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;   // 1: m1 was granted most recently
  logic   sel_stb;
  logic   tmo_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_stb && m1_stb) state_d = last_q ? GNT0 : GNT1;
        else if (m0_stb)      state_d = GNT0;
        else if (m1_stb)      state_d = GNT1;
      end
      GNT0: if (!m0_stb) state_d = m1_stb ? GNT1 : IDLE;
      GNT1: if (!m1_stb) state_d = m0_stb ? GNT0 : IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == GNT0)      last_d = 1'b0;
    else if (state_d == GNT1) last_d = 1'b1;
  end

  assign sel_stb = ((state_q == GNT0) && m0_stb) || ((state_q == GNT1) && m1_stb);

  always_comb begin
    bus_stb  = 1'b0;
    bus_we   = 1'b0;
    bus_addr = '0;
    bus_dout = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    case (state_q)
      GNT0: begin
        bus_stb  = m0_stb;
        bus_we   = m0_we;
        bus_addr = m0_addr;
        bus_dout = m0_dout;
        m0_ack   = bus_ack | tmo_hit;
      end
      GNT1: begin
        bus_stb  = m1_stb;
        bus_we   = m1_we;
        bus_addr = m1_addr;
        bus_dout = m1_dout;
        m1_ack   = bus_ack | tmo_hit;
      end
      default: ;
    endcase
  end

  assign gnt    = {state_q == GNT1, state_q == GNT0};
  assign m0_din = bus_din;
  assign m1_din = bus_din;

`ifdef BUS_ARB_TMO_EN
  localparam logic [TMO_BITS-1:0] CNT_ONE = 1;

  logic [TMO_BITS-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;

  // Fake ack fires on the cycle the stalled-access counter sits at all-ones.
  assign tmo_hit = sel_stb && !bus_ack && (&cnt_q);

  always_comb begin
    cnt_d = cnt_q + CNT_ONE;
    if (!sel_stb || bus_ack || tmo_hit || (state_d != state_q)) cnt_d = '0;
    err_d = err_q;
    if (tmo_hit)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic [TMO_BITS:0] unused_tmo;

  assign tmo_hit    = 1'b0;
  assign err        = 1'b0;
  assign unused_tmo = {(TMO_BITS+1){err_clr}};
`endif

endmodule

// File: tb/tb_bus_arb.sv
// Directed bench for bus_arb: a rule-level ownership model checked every cycle, plus literal pins.
// Timeout scenarios follow BUS_ARB_TMO_EN the same way the design does.
module tb_bus_arb;

  localparam int TMO = 8;
  localparam int TMO_MAX = (1 << TMO) - 1;
`ifdef BUS_ARB_TMO_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk, rst_n;
  logic        m0_stb, m0_we, m1_stb, m1_we;
  logic [29:0] m0_addr, m1_addr, bus_addr;
  logic [31:0] m0_dout, m1_dout, m0_din, m1_din, bus_dout, bus_din;
  logic        m0_ack, m1_ack, bus_stb, bus_we, bus_ack, err, err_clr;
  logic [1:0]  gnt;

  int checks = 0;
  int failures = 0;

  bus_arb #(.TMO_BITS(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_dout(m0_dout),
    .m0_din(m0_din), .m0_ack(m0_ack),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_dout(m1_dout),
    .m1_din(m1_din), .m1_ack(m1_ack),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr), .bus_dout(bus_dout),
    .bus_din(bus_din), .bus_ack(bus_ack),
    .gnt(gnt), .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: owner 0 = nobody, 1 = m0, 2 = m1; lastw = index of the most recent winner.
  int owner, lastw, stall;
  bit exp_err;

  function automatic int pick(input int cur, input bit s0, input bit s1, input int lw);
    if (cur == 1 && s0) return 1;
    if (cur == 2 && s1) return 2;
    if (s0 && s1) return (lw == 0) ? 2 : 1;
    if (s0) return 1;
    if (s1) return 2;
    return 0;
  endfunction

  function automatic bit owner_stb(input int cur);
    return (cur == 1) ? m0_stb : (cur == 2) ? m1_stb : 1'b0;
  endfunction

  function automatic bit tmo_pulse();
    return TMO_EN && owner_stb(owner) && !bus_ack && (stall == TMO_MAX);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner   <= 0;
      lastw   <= 1;
      stall   <= 0;
      exp_err <= 1'b0;
    end else begin
      int nxt;
      bit p;
      nxt = pick(owner, m0_stb, m1_stb, lastw);
      p   = tmo_pulse();
      owner <= nxt;
      if (nxt != 0) lastw <= nxt - 1;
      stall <= (owner_stb(owner) && !bus_ack && !p && nxt == owner) ? stall + 1 : 0;
      if (p) exp_err <= 1'b1;
      else if (err_clr) exp_err <= 1'b0;
    end
  end

  always @(negedge clk) begin
    bit s, p;
    s = owner_stb(owner);
    p = tmo_pulse();
    chk("gnt", {30'd0, gnt}, {30'd0, owner == 2, owner == 1});
    chk("bus_stb", {31'd0, bus_stb}, {31'd0, s});
    chk("bus_we", {31'd0, bus_we}, (owner == 1) ? {31'd0, m0_we} : (owner == 2) ? {31'd0, m1_we} : 32'd0);
    chk("bus_addr", {2'd0, bus_addr}, (owner == 1) ? {2'd0, m0_addr} : (owner == 2) ? {2'd0, m1_addr} : 32'd0);
    chk("bus_dout", bus_dout, (owner == 1) ? m0_dout : (owner == 2) ? m1_dout : 32'd0);
    chk("m0_ack", {31'd0, m0_ack}, {31'd0, owner == 1 && (bus_ack || p)});
    chk("m1_ack", {31'd0, m1_ack}, {31'd0, owner == 2 && (bus_ack || p)});
    chk("m0_din", m0_din, bus_din);
    chk("m1_din", m1_din, bus_din);
    chk("err", {31'd0, err}, {31'd0, exp_err});
  end

  logic [2:0] vec [16] = '{3'b110, 3'b111, 3'b101, 3'b011, 3'b010, 3'b111, 3'b001, 3'b000,
                           3'b100, 3'b111, 3'b010, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000};

  initial begin
    int n;
    rst_n = 1'b0; err_clr = 1'b0; bus_ack = 1'b0; bus_din = 32'h0;
    m0_stb = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_dout = '0;
    m1_stb = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_dout = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_stb", {31'd0, bus_stb}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // single m0 read, slave acks on the third bus cycle
    m0_stb = 1'b1; m0_we = 1'b0; m0_addr = 30'h100;
    tick();
    chk("r36_gnt", {30'd0, gnt}, 32'd1);
    chk("r36_addr", {2'd0, bus_addr}, 32'h100);
    tick(); tick();
    bus_ack = 1'b1; bus_din = 32'hDEADBEEF;
    #1;
    chk("r36_ack", {31'd0, m0_ack}, 32'd1);
    chk("r36_din", m0_din, 32'hDEADBEEF);
    chk("r36_m1ack", {31'd0, m1_ack}, 32'd0);
    m0_stb = 1'b0; bus_ack = 1'b0;
    tick();
    chk("r36_idle", {30'd0, gnt}, 32'd0);

    // tie straight after reset, then direct hand-over
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m0_stb = 1'b1; m1_stb = 1'b1; m0_addr = 30'h10; m1_addr = 30'h20; m1_we = 1'b1;
    tick();
    chk("r37_tie", {30'd0, gnt}, 32'd1);
    bus_ack = 1'b1;
    #1;
    chk("r37_m1ack", {31'd0, m1_ack}, 32'd0);
    tick();
    bus_ack = 1'b0; m0_stb = 1'b0;
    tick();
    chk("r37_handover", {30'd0, gnt}, 32'd2);
    chk("r37_addr", {2'd0, bus_addr}, 32'h20);
    m1_stb = 1'b0;
    tick();
    chk("r37_idle", {30'd0, gnt}, 32'd0);

    // m0 read-modify-write held across two acks while m1 waits
    m0_stb = 1'b1; m0_we = 1'b0; m0_addr = 30'h55; m0_dout = 32'h11;
    tick();
    chk("r38_gnt", {30'd0, gnt}, 32'd1);
    m1_stb = 1'b1; m1_addr = 30'h77; m1_dout = 32'h22; bus_ack = 1'b1;
    #1;
    chk("r38_addr1", {2'd0, bus_addr}, 32'h55);
    tick();
    bus_ack = 1'b0; m0_we = 1'b1; m0_dout = 32'h33;
    tick();
    chk("r38_hold", {30'd0, gnt}, 32'd1);
    bus_ack = 1'b1;
    #1;
    chk("r38_dout", bus_dout, 32'h33);
    chk("r38_addr2", {2'd0, bus_addr}, 32'h55);
    chk("r38_m1ack", {31'd0, m1_ack}, 32'd0);
    tick();
    chk("r38_hold2", {30'd0, gnt}, 32'd1);
    m0_stb = 1'b0; m0_we = 1'b0; bus_ack = 1'b0;
    tick();
    chk("r38_m1", {30'd0, gnt}, 32'd2);
    chk("r38_m1addr", {2'd0, bus_addr}, 32'h77);

    // reset during the m1 write (m1_we still high)
    #2 rst_n = 1'b0;
    #1;
    chk("r39_gnt", {30'd0, gnt}, 32'd0);
    chk("r39_stb", {31'd0, bus_stb}, 32'd0);
    bus_ack = 1'b1;
    #2;
    chk("r39_m1ack", {31'd0, m1_ack}, 32'd0);
    bus_ack = 1'b0; m1_we = 1'b0; m0_stb = 1'b1; m1_stb = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("r39_tie", {30'd0, gnt}, 32'd1);
    m0_stb = 1'b0; m1_stb = 1'b0;
    tick();

    // mixed request/ack vectors, checked cycle by cycle against the model
    for (int i = 0; i < 16; i++) begin
      {m0_stb, m1_stb, bus_ack} = vec[i];
      m0_we = i[0]; m1_we = i[1];
      m0_addr = 30'h1000 + 30'(i); m1_addr = 30'h2000 + 30'(i);
      m0_dout = 32'hA0000000 + 32'(i); m1_dout = 32'hB0000000 + 32'(i);
      bus_din = 32'h01010101 * 32'(i);
      tick();
    end
    m0_stb = 1'b0; m1_stb = 1'b0; bus_ack = 1'b0;
    tick(); tick();

    // slave never acks
    m0_stb = 1'b1; m0_addr = 30'h300;
    tick();
`ifdef BUS_ARB_TMO_EN
    n = 0;
    while (n < 400 && !m0_ack) begin
      tick();
      n++;
    end
    chk("tmo_latency", n, 32'd255);
    tick();
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_single", {31'd0, m0_ack}, 32'd0);
    m0_stb = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo_clr", {31'd0, err}, 32'd0);
`else
    n = 0;
    repeat (1000) begin
      if (m0_ack) n++;
      tick();
    end
    chk("notmo_acks", n, 32'd0);
    chk("notmo_err", {31'd0, err}, 32'd0);
    chk("notmo_stall", {31'd0, bus_stb}, 32'd1);
    m0_stb = 1'b0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
